fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pcWrite  input  1  from hazard unit; 0 = hold PC.
REQ-005 ifIdWrite  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-006 branchTaken  input  1  redirect request from ID stage.
REQ-007 branchTarget  input  32  redirect address.
REQ-008 imemReq  output  1  instruction-memory request.
REQ-009 imemAddr  output  32  fetch address; stable while imemReq=1 and imemReady=0.
REQ-010 imemReady  input  1  memory completion strobe; imemData valid this cycle.
REQ-011 imemData  input  32  fetched instruction word.
REQ-012 ifIdInstr / ifIdPc / ifIdValid  output  32/32/1  IF/ID register: instruction, PC+4, valid.
REQ-013 opCode / ifIdRs / ifIdRt  output  6/5/5  combinational slices [31:26]/[25:21]/[20:16] of ifIdInstr, feeding the hazard unit.

Function
REQ-014 FSM states SHALL be FETCH, HOLD, DRAIN; imemReq=1 in FETCH and DRAIN, 0 in HOLD; imemAddr=pc in FETCH, drainAddr in DRAIN.
REQ-015 advance = pcWrite AND ifIdWrite.
REQ-016 FETCH, imemReady=1, advance=1: IF/ID <= {imemData, pc+4, valid=1}; pc <= pc+4; stay FETCH (one instruction per cycle, zero added latency).
REQ-017 FETCH, imemReady=1, advance=0: imemData SHALL be captured in holdBuf; IF/ID and pc unchanged; go HOLD.
REQ-018 FETCH, imemReady=0: if ifIdWrite=1, IF/ID SHALL load a bubble {32'h0, pc+4, valid=0}; else IF/ID holds.
REQ-019 HOLD, advance=1: IF/ID <= {holdBuf, pc+4, 1}; pc <= pc+4; go FETCH. HOLD, advance=0: all state held.
REQ-020 branchTaken=1 SHALL take priority over stalls: pc <= branchTarget; IF/ID <= {32'h0, 32'h0, 0}; holdBuf discarded.
REQ-021 Branch in FETCH with imemReady=0 (request outstanding): drainAddr <= pc; go DRAIN; the eventual response SHALL be discarded, then go FETCH at the new pc.
REQ-022 Branch in FETCH with imemReady=1, or in HOLD: returned/held word discarded; go FETCH.
REQ-023 Branch in DRAIN: pc updated to newest target; stay DRAIN until imemReady.
REQ-024 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 32'h0.

Reset
REQ-025 Reset SHALL force state=FETCH, pc=0, holdBuf=0, drainAddr=0, ifIdInstr=0, ifIdPc=0, ifIdValid=0; imemReq=0 while reset asserted.
REQ-026 Reset asserted mid-request SHALL abandon the request; the first post-reset cycle SHALL issue imemReq=1, imemAddr=0.

Configuration
REQ-027 Macro FETCH_STALL_COUNT_EN: when defined, output stallCount (16 bits) SHALL count cycles with advance=0 and branchTaken=0, saturating at 16'hFFFF, cleared by reset; when undefined, the port and counter SHALL not exist.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, NOP_INSTR=32'h0, PC_STEP=4, and instruction field positions/widths.
REQ-029 One sub-module, pc_register (load/increment/redirect, async reset), SHALL be instantiated.

Verification
REQ-030 Reset release, imemReady=1 always, advance=1 -> imemAddr 0,4,8; ifIdPc 4,8,12, ifIdValid=1 each cycle.
REQ-031 Word 32'h8C220004 returned with pcWrite=ifIdWrite=0 for 3 cycles -> state HOLD, imemReq=0, IF/ID unchanged; on release ifIdInstr=32'h8C220004, opCode=6'h23.
REQ-032 branchTaken=1, target 32'h100, while request at 32'h10 pending 2 cycles -> imemAddr stays 32'h10, response discarded, next imemAddr=32'h100, ifIdValid=0 meanwhile.
REQ-033 branchTaken=1 and ifIdWrite=0 same cycle -> pc=branchTarget, IF/ID flushed to 0/valid=0.
REQ-034 pc=32'hFFFFFFFC fetch with advance=1 -> next imemAddr=32'h0, ifIdPc=32'h0.
REQ-035 FETCH_STALL_COUNT_EN defined, 5 stalled cycles then reset -> stallCount=5, then 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the fetch stage
// Contents: FSM state enum, NOP/PC step constants, instruction field
// positions/widths, and the PC increment helper used by all fetch files.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RS_W       = 5;
  localparam int RT_LSB     = 16;
  localparam int RT_W       = 5;

  // Modulo-2^32 increment; 32'hFFFFFFFC wraps to 32'h0.
  function automatic logic [31:0] stepPc(input logic [31:0] pcIn);
    return pcIn + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus
// Signals: imemReq/imemAddr (fetch -> memory), imemReady/imemData
// (memory -> fetch). imemAddr is held stable while imemReq=1 and imemReady=0.
// Modports: master (fetch stage side), slave (memory side).
interface fetch_stage_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemData
  );
endinterface

// File: rtl/fetch_stage_pc_register.sv
// rtl/fetch_stage_pc_register.sv - program counter with redirect/increment
// Ports: clk, reset (async, active-high); redirect + target load a new PC
// and take priority over increment; pc is the current value, pcPlus4 the
// wrapped next-sequential address.
module pc_register
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        increment,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= 32'h0;
    end else if (redirect) begin
      pc <= target;
    end else if (increment) begin
      pc <= stepPc(pc);
    end
  end

  assign pcPlus4 = stepPc(pc);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
// Ports: clk, reset (async, active-high); pcWrite/ifIdWrite stall controls
// from the hazard unit; branchTaken/branchTarget redirect from ID; imem
// (fetch_stage_if.master) instruction-memory bus; ifIdInstr/ifIdPc/ifIdValid
// IF/ID register; opCode/ifIdRs/ifIdRt combinational field slices.
// Optional: FETCH_STALL_COUNT_EN adds output stallCount (saturating count of
// cycles with no advance and no branch).
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pcWrite,
  input  logic                ifIdWrite,
  input  logic                branchTaken,
  input  logic [31:0]         branchTarget,
  fetch_stage_if.master       imem,
  output logic [31:0]         ifIdInstr,
  output logic [31:0]         ifIdPc,
  output logic                ifIdValid,
  output logic [OPCODE_W-1:0] opCode,
  output logic [RS_W-1:0]     ifIdRs,
  output logic [RT_W-1:0]     ifIdRt
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [15:0]         stallCount
`endif
);

  fetchState_t state, stateNext;
  logic [31:0] holdBuf, holdBufNext;
  logic [31:0] drainAddr, drainAddrNext;
  logic [31:0] ifIdInstrNext, ifIdPcNext;
  logic        ifIdValidNext;
  logic        pcRedirect, pcIncrement;
  logic [31:0] pc, pcPlus4;
  logic        advance;

  assign advance = pcWrite & ifIdWrite;

  pc_register uPc (
    .clk      (clk),
    .reset    (reset),
    .redirect (pcRedirect),
    .target   (branchTarget),
    .increment(pcIncrement),
    .pc       (pc),
    .pcPlus4  (pcPlus4)
  );

  // Gated by reset so an in-flight request is dropped the moment reset hits.
  assign imem.imemReq  = !reset && (state == FETCH || state == DRAIN);
  // In DRAIN the outstanding request keeps its original address even after
  // pc has moved on to the branch target.
  assign imem.imemAddr = (state == DRAIN) ? drainAddr : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      holdBuf   <= NOP_INSTR;
      drainAddr <= 32'h0;
      ifIdInstr <= NOP_INSTR;
      ifIdPc    <= 32'h0;
      ifIdValid <= 1'b0;
    end else begin
      state     <= stateNext;
      holdBuf   <= holdBufNext;
      drainAddr <= drainAddrNext;
      ifIdInstr <= ifIdInstrNext;
      ifIdPc    <= ifIdPcNext;
      ifIdValid <= ifIdValidNext;
    end
  end

  always_comb begin
    stateNext     = state;
    holdBufNext   = holdBuf;
    drainAddrNext = drainAddr;
    ifIdInstrNext = ifIdInstr;
    ifIdPcNext    = ifIdPc;
    ifIdValidNext = ifIdValid;
    pcRedirect    = 1'b0;
    pcIncrement   = 1'b0;

    if (branchTaken) begin
      // Redirect wins over any stall: flush IF/ID and drop buffered words.
      pcRedirect    = 1'b1;
      ifIdInstrNext = NOP_INSTR;
      ifIdPcNext    = 32'h0;
      ifIdValidNext = 1'b0;
      holdBufNext   = NOP_INSTR;
      case (state)
        FETCH: begin
          if (!imem.imemReady) begin
            drainAddrNext = pc;
            stateNext     = DRAIN;
          end else begin
            stateNext = FETCH;
          end
        end
        HOLD:    stateNext = FETCH;
        DRAIN:   stateNext = imem.imemReady ? FETCH : DRAIN;
        default: stateNext = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem.imemReady) begin
            if (advance) begin
              ifIdInstrNext = imem.imemData;
              ifIdPcNext    = pcPlus4;
              ifIdValidNext = 1'b1;
              pcIncrement   = 1'b1;
            end else begin
              holdBufNext = imem.imemData;
              stateNext   = HOLD;
            end
          end else if (ifIdWrite) begin
            ifIdInstrNext = NOP_INSTR;
            ifIdPcNext    = pcPlus4;
            ifIdValidNext = 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            ifIdInstrNext = holdBuf;
            ifIdPcNext    = pcPlus4;
            ifIdValidNext = 1'b1;
            pcIncrement   = 1'b1;
            stateNext     = FETCH;
          end
        end
        DRAIN: begin
          // The response to the abandoned request is thrown away.
          if (imem.imemReady) begin
            stateNext = FETCH;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  assign opCode = ifIdInstr[OPCODE_LSB +: OPCODE_W];
  assign ifIdRs = ifIdInstr[RS_LSB +: RS_W];
  assign ifIdRt = ifIdInstr[RT_LSB +: RT_W];

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= 16'h0;
    end else if (!advance && !branchTaken && stallCount != 16'hFFFF) begin
      stallCount <= stallCount + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcWrite = 1'b0;
  logic        ifIdWrite = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic [31:0] ifIdInstr, ifIdPc;
  logic        ifIdValid;
  logic [5:0]  opCode;
  logic [4:0]  ifIdRs, ifIdRt;
`ifdef FETCH_STALL_COUNT_EN
  logic [15:0] stallCount;
`endif

  fetch_stage_if imemBus ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .pcWrite     (pcWrite),
    .ifIdWrite   (ifIdWrite),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .imem        (imemBus),
    .ifIdInstr   (ifIdInstr),
    .ifIdPc      (ifIdPc),
    .ifIdValid   (ifIdValid),
    .opCode      (opCode),
    .ifIdRs      (ifIdRs),
    .ifIdRt      (ifIdRt)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stallCount  (stallCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pw, iw, br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] data;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expVld;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  vec_t vecs[21];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pw, input logic iw, input logic br,
                              input logic [31:0] tgt, input logic rdy, input logic [31:0] data,
                              input logic expReq, input logic [31:0] expAddr,
                              input logic expVld, input logic [31:0] expPc,
                              input logic [31:0] expInstr);
    vec_t v;
    v.pw = pw; v.iw = iw; v.br = br; v.tgt = tgt; v.rdy = rdy; v.data = data;
    v.expReq = expReq; v.expAddr = expAddr;
    v.expVld = expVld; v.expPc = expPc; v.expInstr = expInstr;
    return v;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h2400_0000 | addr;
  endfunction

  initial begin
    logic [31:0] expA;
    logic [31:0] ei;
    sbEntry_t e;

    //          pw iw br tgt            rdy data            req addr          vld ifIdPc        instr
    vecs[0]  = mk(0, 0, 0, 32'h0,        1, 32'h8C220004,   1, 32'h0000000C,  1, 32'h0000000C, memWord(32'h8));
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000000C, memWord(32'h8));
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000000C, memWord(32'h8));
    vecs[3]  = mk(1, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h00000010, 32'h8C220004);
    vecs[4]  = mk(1, 1, 1, 32'h100,      0, 32'h0,          1, 32'h00000010,  0, 32'h0,        32'h0);
    vecs[5]  = mk(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h00000010,  0, 32'h0,        32'h0);
    vecs[6]  = mk(1, 1, 0, 32'h0,        1, 32'hDEADBEEF,   1, 32'h00000010,  0, 32'h0,        32'h0);
    vecs[7]  = mk(1, 1, 0, 32'h0,        1, 32'h20010001,   1, 32'h00000100,  1, 32'h00000104, 32'h20010001);
    vecs[8]  = mk(1, 0, 1, 32'h200,      1, 32'h20020002,   1, 32'h00000104,  0, 32'h0,        32'h0);
    vecs[9]  = mk(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h00000200,  0, 32'h00000204, 32'h0);
    vecs[10] = mk(1, 1, 0, 32'h0,        1, 32'h20030003,   1, 32'h00000200,  1, 32'h00000204, 32'h20030003);
    vecs[11] = mk(1, 0, 0, 32'h0,        0, 32'h0,          1, 32'h00000204,  1, 32'h00000204, 32'h20030003);
    vecs[12] = mk(0, 1, 0, 32'h0,        0, 32'h0,          1, 32'h00000204,  0, 32'h00000208, 32'h0);
    vecs[13] = mk(0, 1, 0, 32'h0,        1, 32'h20040004,   1, 32'h00000204,  0, 32'h00000208, 32'h0);
    vecs[14] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0);
    vecs[15] = mk(1, 1, 0, 32'h0,        1, 32'h20050005,   1, 32'hFFFFFFFC,  1, 32'h0,        32'h20050005);
    vecs[16] = mk(1, 1, 0, 32'h0,        1, 32'h20060006,   1, 32'h00000000,  1, 32'h00000004, 32'h20060006);
    vecs[17] = mk(1, 1, 1, 32'h40,       0, 32'h0,          1, 32'h00000004,  0, 32'h0,        32'h0);
    vecs[18] = mk(1, 1, 1, 32'h80,       0, 32'h0,          1, 32'h00000004,  0, 32'h0,        32'h0);
    vecs[19] = mk(1, 1, 0, 32'h0,        1, 32'h20070007,   1, 32'h00000004,  0, 32'h0,        32'h0);
    vecs[20] = mk(1, 1, 0, 32'h0,        1, 32'h20080008,   1, 32'h00000080,  1, 32'h00000084, 32'h20080008);

    imemBus.imemReady = 1'b0;
    imemBus.imemData  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check32("reset imemReq", {31'h0, imemBus.imemReq}, 32'h0);
    check32("reset ifIdValid", {31'h0, ifIdValid}, 32'h0);
    check32("reset ifIdPc", ifIdPc, 32'h0);
    check32("reset ifIdInstr", ifIdInstr, 32'h0);
    reset = 1'b0;

    // Streaming fetch, memory always ready, no stalls
    expA = 32'h0;
    for (int i = 0; i < 3; i++) begin
      pcWrite = 1'b1; ifIdWrite = 1'b1; branchTaken = 1'b0;
      imemBus.imemReady = 1'b1;
      imemBus.imemData  = memWord(expA);
      #1;
      check32("stream imemReq", {31'h0, imemBus.imemReq}, 32'h1);
      check32("stream imemAddr", imemBus.imemAddr, expA);
      e.instr = memWord(expA);
      e.pc    = expA + 32'd4;
      sbQ.push_back(e);
      expA = expA + 32'd4;
      @(posedge clk);
      #1;
      if (ifIdValid === 1'b1 && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        check32("stream ifIdInstr", ifIdInstr, e.instr);
        check32("stream ifIdPc", ifIdPc, e.pc);
      end else begin
        checks++;
        errors++;
        $display("FAIL stream ifIdValid: got %b expected 1", ifIdValid);
      end
    end
    check32("scoreboard empty", sbQ.size(), 32'd0);

    // Table-driven stall / branch / wrap vectors
    for (int i = 0; i < 21; i++) begin
      pcWrite           = vecs[i].pw;
      ifIdWrite         = vecs[i].iw;
      branchTaken       = vecs[i].br;
      branchTarget      = vecs[i].tgt;
      imemBus.imemReady = vecs[i].rdy;
      imemBus.imemData  = vecs[i].data;
      #1;
      check32($sformatf("v%0d imemReq", i), {31'h0, imemBus.imemReq}, {31'h0, vecs[i].expReq});
      if (vecs[i].expReq)
        check32($sformatf("v%0d imemAddr", i), imemBus.imemAddr, vecs[i].expAddr);
      @(posedge clk);
      #1;
      ei = vecs[i].expInstr;
      check32($sformatf("v%0d ifIdValid", i), {31'h0, ifIdValid}, {31'h0, vecs[i].expVld});
      check32($sformatf("v%0d ifIdPc", i), ifIdPc, vecs[i].expPc);
      check32($sformatf("v%0d ifIdInstr", i), ifIdInstr, ei);
      check32($sformatf("v%0d opCode", i), {26'h0, opCode}, {26'h0, ei[31:26]});
      check32($sformatf("v%0d ifIdRs", i), {27'h0, ifIdRs}, {27'h0, ei[25:21]});
      check32($sformatf("v%0d ifIdRt", i), {27'h0, ifIdRt}, {27'h0, ei[20:16]});
      if (i == 3)
        check32("released opCode", {26'h0, opCode}, 32'h23);
    end

    // Reset in the middle of an outstanding request
    pcWrite = 1'b1; ifIdWrite = 1'b1; branchTaken = 1'b0;
    imemBus.imemReady = 1'b0;
    #1;
    check32("pre-reset imemAddr", imemBus.imemAddr, 32'h84);
    #2;
    reset = 1'b1;
    #1;
    check32("mid reset imemReq", {31'h0, imemBus.imemReq}, 32'h0);
    check32("mid reset ifIdValid", {31'h0, ifIdValid}, 32'h0);
    check32("mid reset ifIdPc", ifIdPc, 32'h0);
    check32("mid reset ifIdInstr", ifIdInstr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pcWrite = 1'b0; ifIdWrite = 1'b0;
    #1;
    check32("post reset imemReq", {31'h0, imemBus.imemReq}, 32'h1);
    check32("post reset imemAddr", imemBus.imemAddr, 32'h0);

`ifdef FETCH_STALL_COUNT_EN
    repeat (5) @(posedge clk);
    #1;
    check32("stallCount after 5 stalls", {16'h0, stallCount}, 32'd5);
    reset = 1'b1;
    #1;
    check32("stallCount after reset", {16'h0, stallCount}, 32'd0);
    reset = 1'b0;
`endif

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
